store_align_unit: RTL and testbench
===================================

Name: store_align_unit

Overview:
- Write-side counterpart of the immediate/load extension path. It narrows 32-bit register store data to byte, halfword or word.
- Replicates the data into the correct byte lanes, generates byte enables, and issues the write to data memory over a valid/ready handshake.
- Tracks outstanding writes until the memory acknowledges them.
- Sits between the MEM pipeline stage and the data-memory port. It also flags misaligned or illegal stores for the exception unit.

Parameters:
- MAX_OUTSTANDING, 2, maximum issued-but-unacknowledged writes (1..7).
- CNT_W, 3, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept the request this cycle.
- req_op  in  3  store op: 000 SB, 001 SH, 010 SW, 100 SWL, 101 SWR; others illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  register data (rt).
- mem_valid  out  1  write request to memory.
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i covers mem_wdata[8i+7:8i].
- mem_ack  in  1  one-cycle pulse: one earlier write completed.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  2  01 misaligned (AdES), 10 illegal op.
- exc_badvaddr  out  32  faulting req_addr.
- idle  out  1  no pending output and no outstanding writes.

Behaviour:
- Reset (async, rst_n low): mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, exc_valid=0, exc_cause=0, exc_badvaddr=0, outstanding count=0, idle=1.
- Accept: a request is accepted when req_valid && req_ready.
- req_ready = (!mem_valid || mem_ready) && (cnt + mem_valid < MAX_OUTSTANDING). A same-cycle mem_ack is ignored (conservative).
- Latency: a legal accepted request drives mem_valid=1 with registered addr/wdata/be on the next cycle.
- Stability: mem_* stay stable while mem_valid && !mem_ready.
- Back-to-back: supported when mem_ready is high every cycle.
- Lane rules (little-endian, a = req_addr[1:0]):
  - SB: wdata={4{d[7:0]}}, be=0001<<a.
  - SH: wdata={2{d[15:0]}}, be = a[1] ? 1100 : 0011. Misaligned if a[0].
  - SW: wdata=d, be=1111. Misaligned if a!=0.
- Faulting requests (misaligned or illegal op):
  - Accepted normally and consume no memory slot.
  - No mem_valid is issued.
  - exc_valid pulses for exactly 1 cycle the cycle after acceptance, with cause and badvaddr.
  - A faulting request accepted while mem_valid is pending does not disturb the pending write.
- Counter:
  - +1 on mem_valid && mem_ready; -1 on mem_ack; both in one cycle leaves it unchanged.
  - mem_ack with cnt=0 is a protocol error: ignored (saturate at 0), with an assertion in simulation.
  - The counter never exceeds MAX_OUTSTANDING.
- idle = !mem_valid && cnt==0.
- State machine, per output slot:
  - EMPTY -> FULL on legal accept.
  - FULL -> EMPTY on mem_ready without a new accept.
  - FULL -> FULL on mem_ready plus a new legal accept.
- Reset mid-transaction: pending writes and the count are discarded; memory-side consistency is owned by the system reset.

Optional Feature:
- Macro: STORE_ALIGN_SWLR_EN.
- Defined: SWL/SWR are legal unaligned partial-word stores (little-endian).
  - SWL: a=0 be=0001 lane0=d[31:24]; a=1 be=0011 lanes1:0=d[31:16]; a=2 be=0111 lanes2:0=d[31:8]; a=3 be=1111 d.
  - SWR: a=0 be=1111 d; a=1 be=1110 lanes3:1=d[23:0]; a=2 be=1100 lanes3:2=d[15:0]; a=3 be=1000 lane3=d[7:0].
  - Never misaligned.
- Undefined: ops 100/101 are illegal (exc_cause=10), with no memory write.

Decomposition:
- Package store_pkg:
  - store_op_e enum (SB/SH/SW/SWL/SWR).
  - exc_cause_e enum (NONE/ADES/ILLEGAL).
  - BE_BYTE/BE_HALF_LO/BE_HALF_HI/BE_WORD constants.
- Sub-module store_lane_gen: purely combinational (op, addr[1:0], wdata) -> (be, lane_data, cause). It is instantiated once in store_align_unit, and the registered slot, counter and exception pulse stay at the top level.

Test Plan:
- SB addr=0x1003 wdata=0x000000AB, mem_ready=1 -> next cycle mem_addr=0x1000, mem_wdata=0xABABABAB, mem_be=1000.
- SH addr=0x2001 -> no mem_valid; exc_valid pulse one cycle, exc_cause=01, exc_badvaddr=0x2001.
- SW addr=0x3000 wdata=0xDEADBEEF with mem_ready=0 for 3 cycles -> mem_* held stable, req_ready=0; issued on the 4th cycle.
- MAX_OUTSTANDING=2, three SW with mem_ack withheld -> third blocked (req_ready=0) until mem_ack pulses; then idle=1 after all acks.
- SWR addr=0x4002 wdata=0x11223344 -> with macro: be=1100, mem_wdata[31:16]=0x3344; without macro: exc_cause=10, no write.
- Assert rst_n low while mem_valid=1 and cnt=1 -> mem_valid=0, idle=1 immediately (async); normal operation after release.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and byte-enable constants for the store alignment path.
package store_pkg;

  typedef enum logic [2:0] {
    SB  = 3'b000,
    SH  = 3'b001,
    SW  = 3'b010,
    SWL = 3'b100,
    SWR = 3'b101
  } store_op_e;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    ADES    = 2'b01,
    ILLEGAL = 2'b10
  } exc_cause_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane steering: op + low address bits -> byte enables, lane data, fault cause.
// SWL/SWR are legal only when STORE_ALIGN_SWLR_EN is defined.
module store_lane_gen
  import store_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output exc_cause_e  cause
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be        = '0;
    lane_data = '0;
    cause     = NONE;
    case (store_op_e'(op))
      SB: begin
        lane_data = {4{wdata[7:0]}};
        be        = BE_BYTE << addr_lo;
      end
      SH: begin
        lane_data = {2{wdata[15:0]}};
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        if (addr_lo[0]) cause = ADES;
      end
      SW: begin
        lane_data = wdata;
        be        = BE_WORD;
        if (addr_lo != 2'b00) cause = ADES;
      end
`ifdef STORE_ALIGN_SWLR_EN
      // SWL writes the top (a+1) bytes of rt into lanes a..0; SWR writes the low bytes into lanes 3..a.
      SWL: begin
        lane_data = wdata >> {~addr_lo, 3'b000};
        be        = BE_WORD >> ~addr_lo;
      end
      SWR: begin
        lane_data = wdata << {addr_lo, 3'b000};
        be        = BE_WORD << addr_lo;
      end
`endif
      default: cause = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: registered write slot, outstanding-write counter, exception pulse.
// Optional SWL/SWR support via STORE_ALIGN_SWLR_EN.
module store_align_unit
  import store_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_badvaddr,
  output logic        idle
);

  slot_state_e      slot_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   in_flight;
  logic [3:0]       lane_be;
  logic [31:0]      lane_data;
  exc_cause_e       lane_cause;
  logic             accept, fault, issue, ack_eff;

  store_lane_gen u_lane_gen (
    .op        (req_op),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (lane_be),
    .lane_data (lane_data),
    .cause     (lane_cause)
  );

  assign mem_valid = (slot_q == FULL);
  assign idle      = !mem_valid && (cnt_q == '0);

  // A same-cycle ack is deliberately not credited, keeping ready off the ack path.
  assign in_flight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, mem_valid};
  assign req_ready = (!mem_valid || mem_ready) && (in_flight < (CNT_W+1)'(MAX_OUTSTANDING));

  assign accept  = req_valid && req_ready;
  assign fault   = (lane_cause != NONE);
  assign issue   = mem_valid && mem_ready;
  assign ack_eff = mem_ack && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= EMPTY;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      cnt_q        <= '0;
      exc_valid    <= 1'b0;
      exc_cause    <= '0;
      exc_badvaddr <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept && !fault) begin
        slot_q    <= FULL;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= lane_data;
        mem_be    <= lane_be;
      end else if (mem_ready) begin
        slot_q <= EMPTY;
      end

      case ({issue, ack_eff})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      exc_valid <= accept && fault;
      if (accept && fault) begin
        exc_cause    <= lane_cause;
        exc_badvaddr <= req_addr;
      end
    end
  end

`ifndef SYNTHESIS
  a_ack_underflow: assert property (@(posedge clk) disable iff (!rst_n) mem_ack |-> (cnt_q != '0));
  a_cnt_bound:     assert property (@(posedge clk) disable iff (!rst_n) in_flight <= (CNT_W+1)'(MAX_OUTSTANDING));
`endif

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: vector table plus stall, credit, fault and reset sequences.
module tb_store_align_unit;
  import store_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_badvaddr;
  logic        idle;

  int total = 0;
  int bad   = 0;

  store_align_unit #(.MAX_OUTSTANDING(2), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_badvaddr(exc_badvaddr),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [31:0] emask;
    logic [3:0]  ebe;
    logic [1:0]  ecause;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    vt[0] = '{3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b1, 32'h0000_1000, 32'hABAB_ABAB, 32'hFFFF_FFFF, 4'b1000, 2'b00};
    vt[1] = '{3'b000, 32'h0000_1000, 32'h1234_5678, 1'b1, 32'h0000_1000, 32'h7878_7878, 32'hFFFF_FFFF, 4'b0001, 2'b00};
    vt[2] = '{3'b001, 32'h0000_2002, 32'hCAFE_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 32'hFFFF_FFFF, 4'b1100, 2'b00};
    vt[3] = '{3'b001, 32'h0000_2000, 32'h0000_A5A5, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 4'b0011, 2'b00};
    vt[4] = '{3'b001, 32'h0000_2001, 32'h0000_1111, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b01};
    vt[5] = '{3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'b1111, 2'b00};
    vt[6] = '{3'b010, 32'h0000_3002, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b01};
    vt[7] = '{3'b011, 32'h0000_5000, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b10};
    vt[8] = '{3'b111, 32'h0000_5001, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b10};
`ifdef STORE_ALIGN_SWLR_EN
    vt[9]  = '{3'b101, 32'h0000_4002, 32'h1122_3344, 1'b1, 32'h0000_4000, 32'h3344_0000, 32'hFFFF_0000, 4'b1100, 2'b00};
    vt[10] = '{3'b100, 32'h0000_4001, 32'h1122_3344, 1'b1, 32'h0000_4000, 32'h0000_1122, 32'h0000_FFFF, 4'b0011, 2'b00};
`else
    vt[9]  = '{3'b101, 32'h0000_4002, 32'h1122_3344, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b10};
    vt[10] = '{3'b100, 32'h0000_4001, 32'h1122_3344, 1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b10};
`endif

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_ack = 1'b0;
    #1;
    check("rst mem_valid", mem_valid, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst mem_be", mem_be, 0);
    check("rst exc_valid", exc_valid, 0);
    check("rst exc_cause", exc_cause, 0);
    check("rst exc_badvaddr", exc_badvaddr, 0);
    check("rst idle", idle, 1);
    #11 rst_n = 1'b1;
    step();

    // Table: one request at a time, acknowledged before the next one
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].op, vt[i].addr, vt[i].wdata);
      check($sformatf("v%0d req_ready", i), req_ready, 1);
      step();
      req_valid = 1'b0;
      check($sformatf("v%0d mem_valid", i), mem_valid, vt[i].wr);
      check($sformatf("v%0d exc_valid", i), exc_valid, !vt[i].wr);
      if (vt[i].wr) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, vt[i].eaddr);
        check($sformatf("v%0d mem_wdata", i), mem_wdata & vt[i].emask, vt[i].edata & vt[i].emask);
        check($sformatf("v%0d mem_be", i), mem_be, vt[i].ebe);
      end else begin
        check($sformatf("v%0d exc_cause", i), exc_cause, vt[i].ecause);
        check($sformatf("v%0d exc_badvaddr", i), exc_badvaddr, vt[i].addr);
      end
      step();
      check($sformatf("v%0d mem_valid drop", i), mem_valid, 0);
      check($sformatf("v%0d exc_valid drop", i), exc_valid, 0);
      check($sformatf("v%0d idle", i), idle, !vt[i].wr);
      if (vt[i].wr) begin
        pulse_ack();
        check($sformatf("v%0d idle after ack", i), idle, 1);
      end
    end

    // Backpressure: slot must hold steady while mem_ready is low
    mem_ready = 1'b0;
    drive(3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d mem_valid", k), mem_valid, 1);
      check($sformatf("stall%0d mem_addr", k), mem_addr, 32'h0000_3000);
      check($sformatf("stall%0d mem_wdata", k), mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("stall%0d mem_be", k), mem_be, 4'b1111);
      check($sformatf("stall%0d req_ready", k), req_ready, 0);
      step();
    end
    mem_ready = 1'b1;
    check("stall issue mem_valid", mem_valid, 1);
    step();
    check("stall done mem_valid", mem_valid, 0);
    check("stall done idle", idle, 0);
    pulse_ack();
    check("stall acked idle", idle, 1);

    // Credit limit: two writes in flight block the third until an ack
    drive(3'b010, 32'h0000_6000, 32'h1);
    check("cred r1 ready", req_ready, 1);
    step();
    drive(3'b010, 32'h0000_6004, 32'h2);
    check("cred r2 ready", req_ready, 1);
    step();
    check("cred r2 mem_addr", mem_addr, 32'h0000_6004);
    drive(3'b010, 32'h0000_6008, 32'h3);
    check("cred r3 blocked", req_ready, 0);
    step();
    check("cred slot empty", mem_valid, 0);
    check("cred still blocked", req_ready, 0);
    check("cred not idle", idle, 0);
    pulse_ack();
    check("cred r3 ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("cred r3 mem_valid", mem_valid, 1);
    check("cred r3 mem_addr", mem_addr, 32'h0000_6008);
    step();
    check("cred full again", req_ready, 0);
    pulse_ack();
    step();
    pulse_ack();
    check("cred all acked idle", idle, 1);

    // Faulting request accepted while a write is being issued
    drive(3'b010, 32'h0000_7000, 32'h7);
    step();
    drive(3'b001, 32'h0000_7001, 32'h8);
    check("fault pend ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("fault pend exc_valid", exc_valid, 1);
    check("fault pend cause", exc_cause, 2'b01);
    check("fault pend badvaddr", exc_badvaddr, 32'h0000_7001);
    check("fault pend mem_valid", mem_valid, 0);
    check("fault pend mem_addr", mem_addr, 32'h0000_7000);
    step();
    check("fault pend pulse end", exc_valid, 0);
    pulse_ack();
    check("fault pend idle", idle, 1);

    // Asynchronous reset with one write outstanding and one pending
    drive(3'b010, 32'h0000_8000, 32'h9);
    step();
    drive(3'b010, 32'h0000_8004, 32'hA);
    step();
    req_valid = 1'b0;
    mem_ready = 1'b0;
    check("rstmid pending", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid mem_valid", mem_valid, 0);
    check("rstmid idle", idle, 1);
    check("rstmid mem_addr", mem_addr, 0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    drive(3'b000, 32'h0000_9001, 32'h0000_005A);
    step();
    req_valid = 1'b0;
    check("post rst mem_be", mem_be, 4'b0010);
    check("post rst mem_wdata", mem_wdata, 32'h5A5A_5A5A);
    step();
    check("post rst ready", req_ready, 1);
    pulse_ack();
    check("post rst idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
